// File: rtl/imem_sched_pkg.sv
// Shared types and constants for the instruction-memory boot/run scheduler.
package imem_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam int IMEM_ADDR_W  = 11;
    localparam int INSTR_W      = 32;
    localparam int PERF_CNT_W   = 32;
    localparam int FLUSH_CNT_W  = 4;

endpackage

// File: rtl/imem_perf_cnt.sv
// Enable-and-clear wrapping counter used for the scheduler performance counters.
module imem_perf_cnt
    import imem_sched_pkg::*;
#(
    parameter int W = PERF_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear has priority so a count in the clearing cycle is not kept.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/imem_sched.sv
// Boot-and-run scheduler sharing the instruction memory between loader and fetch.
// Optional performance counters are built when IMEM_SCHED_PERF_EN is defined.
module imem_sched
    import imem_sched_pkg::*;
#(
    parameter int ADDR_W       = IMEM_ADDR_W,
    parameter int DATA_W       = INSTR_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              run_start,
    input  logic              halt_req,
    input  logic              hazard_stall,
    input  logic              pcsrc_e,
    output logic              stall_f,
    output logic              pc_rst,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        state_o,
    output logic              load_err,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       redir_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_e state_q, state_d;

    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   err_q, err_d;
    logic                   load_ok_q, load_ok_d;
    logic [FLUSH_CNT_W-1:0] flush_q, flush_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      waddr_q, waddr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;

    logic accept;
    logic at_top;
    logic flush_done;
    logic enter_load;
    logic enter_flush;

    assign accept     = load_valid && (state_q == ST_LOAD);
    assign at_top     = (addr_q == '1);
    assign flush_done = (flush_q == FLUSH_LAST);
    assign enter_load  = (state_d == ST_LOAD)  && (state_q != ST_LOAD);
    assign enter_flush = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end else if (run_start && load_ok_q) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (load_last) begin
                        state_d = ST_FLUSH;
                    end else if (at_top) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: if (flush_done) state_d = ST_RUN;
            ST_RUN:   if (halt_req) state_d = ST_HALT;
            ST_HALT: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end else if (run_start) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_rst     = 1'b1;
        stall_f    = 1'b1;
        load_ready = 1'b0;
        case (state_q)
            ST_LOAD: load_ready = 1'b1;
            ST_RUN: begin
                pc_rst  = 1'b0;
                stall_f = hazard_stall;
            end
            ST_HALT: pc_rst = 1'b0;
            default: ;
        endcase
    end

    // Load bookkeeping, flush timer and the one-cycle-delayed write port.
    always_comb begin
        addr_d    = addr_q;
        err_d     = err_q;
        load_ok_d = load_ok_q;
        flush_d   = flush_q;
        if (enter_load) begin
            addr_d    = '0;
            err_d     = 1'b0;
            load_ok_d = 1'b0;
        end else if (accept) begin
            addr_d = addr_q + ADDR_W'(1);
            if (load_last) begin
                load_ok_d = 1'b1;
            end else if (at_top) begin
                err_d = 1'b1;
            end
        end
        if (enter_flush) begin
            flush_d = '0;
        end else if (state_q == ST_FLUSH) begin
            flush_d = flush_q + FLUSH_CNT_W'(1);
        end
        we_d    = accept;
        waddr_d = accept ? addr_q : waddr_q;
        wdata_d = accept ? load_data : wdata_q;
    end

    // The asynchronous reset also kills a write still pending on the port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
            flush_q   <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            addr_q    <= addr_d;
            err_q     <= err_d;
            load_ok_q <= load_ok_d;
            flush_q   <= flush_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;
    assign state_o   = state_q;
    assign load_err  = err_q;

`ifdef IMEM_SCHED_PERF_EN
    logic run_q;
    assign run_q = (state_q == ST_RUN);

    imem_perf_cnt #(.W(PERF_CNT_W)) u_fetch_cnt (
        .clk   (clock),
        .rst_n (reset_n),
        .clr_i (enter_flush),
        .en_i  (run_q && !stall_f),
        .cnt_o (fetch_cnt)
    );

    imem_perf_cnt #(.W(PERF_CNT_W)) u_redir_cnt (
        .clk   (clock),
        .rst_n (reset_n),
        .clr_i (enter_flush),
        .en_i  (run_q && pcsrc_e),
        .cnt_o (redir_cnt)
    );
`else
    logic unused_perf;
    assign unused_perf = &{1'b0, pcsrc_e};
    assign fetch_cnt   = '0;
    assign redir_cnt   = '0;
`endif

endmodule

// File: tb/tb_imem_sched.sv
// Directed self-checking bench for imem_sched; write port checked by a scoreboard.
module tb_imem_sched;
    import imem_sched_pkg::*;

    localparam int AW = IMEM_ADDR_W;
    localparam int DW = INSTR_W;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          load_start, load_valid, load_last, run_start, halt_req;
    logic          hazard_stall, pcsrc_e;
    logic [DW-1:0] load_data;
    logic          load_ready, stall_f, pc_rst, mem_we, load_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    state_o;
    logic [31:0]   fetch_cnt, redir_cnt;

    always #5 clock = ~clock;

    imem_sched #(.ADDR_W(AW), .DATA_W(DW), .FLUSH_CYCLES(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .run_start    (run_start),
        .halt_req     (halt_req),
        .hazard_stall (hazard_stall),
        .pcsrc_e      (pcsrc_e),
        .stall_f      (stall_f),
        .pc_rst       (pc_rst),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .state_o      (state_o),
        .load_err     (load_err),
        .fetch_cnt    (fetch_cnt),
        .redir_cnt    (redir_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            c;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  wr_count = 0;
    int  exp_addr = 0;

    // Every write must match the next expected accept, exactly one cycle later.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (mem_we === 1'b1) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    check("spurious_we", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", mem_addr, mon_e.a);
                    check("wr_data", mem_wdata, mon_e.d);
                    check("wr_cycle", cyc, mon_e.c);
                end
            end else if (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
                check("missing_we", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_cmd(input logic do_load, input logic do_run, input logic do_halt);
        load_start = do_load;
        run_start  = do_run;
        halt_req   = do_halt;
        if (do_load) exp_addr = 0;
        step();
        load_start = 1'b0;
        run_start  = 1'b0;
        halt_req   = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last);
        int n;
        n = 0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        #1;
        while (load_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n == 50) check("ready_timeout", load_ready, 1'b1);
        exp_q.push_back('{a: AW'(exp_addr), d: d, c: cyc + 1});
        exp_addr++;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_state(input state_e s, input string tag);
        int n;
        n = 0;
        while (state_o !== s && n < 20) begin
            step();
            n++;
        end
        check(tag, state_o, s);
    endtask

    int wr_base;
    logic exp_stall;
    logic [31:0] exp_fetch, exp_redir;

    initial begin
        reset_n = 1'b0;
        {load_start, load_valid, load_last, run_start, halt_req} = '0;
        {hazard_stall, pcsrc_e} = '0;
        load_data = '0;
        #1;
        check("rst_state", state_o, ST_IDLE);
        check("rst_pc_rst", pc_rst, 1);
        check("rst_stall_f", stall_f, 1);
        check("rst_ready", load_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_err", load_err, 0);
        check("rst_fetch_cnt", fetch_cnt, 0);
        check("rst_redir_cnt", redir_cnt, 0);
        repeat (2) step();
        reset_n = 1'b1;
        step();

        // run_start before any good load is ignored
        pulse_cmd(1'b0, 1'b1, 1'b0);
        check("idle_run_ignored", state_o, ST_IDLE);

        // Basic 3-word load into FLUSH then RUN
        pulse_cmd(1'b1, 1'b0, 1'b0);
        check("load_state", state_o, ST_LOAD);
        check("load_ready", load_ready, 1);
        check("load_pc_rst", pc_rst, 1);
        wr_base = wr_count;
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        send_word(32'h0020_8113, 1'b1);
        check("flush1_state", state_o, ST_FLUSH);
        check("flush1_pc_rst", pc_rst, 1);
        check("flush1_ready", load_ready, 0);
        step();
        check("flush2_state", state_o, ST_FLUSH);
        check("flush2_stall_f", stall_f, 1);
        step();
        check("run_state", state_o, ST_RUN);
        check("run_pc_rst", pc_rst, 0);
        check("run_stall_f", stall_f, 0);
        check("basic_writes", wr_count - wr_base, 3);

        // HALT, then load and run together: load wins
        pulse_cmd(1'b0, 1'b0, 1'b1);
        check("halt_state", state_o, ST_HALT);
        check("halt_stall_f", stall_f, 1);
        check("halt_pc_rst", pc_rst, 0);
        pulse_cmd(1'b1, 1'b1, 1'b0);
        check("halt_load_wins", state_o, ST_LOAD);

        // Loader offering a word every other cycle
        wr_base = wr_count;
        for (int i = 0; i < 4; i++) begin
            send_word(32'hC0DE_0000 + 32'(i), i == 3);
            if (i != 3) step();
        end
        wait_state(ST_RUN, "toggle_to_run");
        check("toggle_writes", wr_count - wr_base, 4);
        check("toggle_drained", exp_q.size(), 0);

        // Overflow: 2048 words without load_last
        pulse_cmd(1'b0, 1'b0, 1'b1);
        pulse_cmd(1'b1, 1'b0, 1'b0);
        wr_base = wr_count;
        for (int i = 0; i < 2048; i++) send_word(32'h5000_0000 + 32'(i), 1'b0);
        check("ovf_state", state_o, ST_IDLE);
        check("ovf_err", load_err, 1);
        check("ovf_ready", load_ready, 0);
        repeat (2) step();
        check("ovf_writes", wr_count - wr_base, 2048);
        check("ovf_drained", exp_q.size(), 0);
        pulse_cmd(1'b0, 1'b1, 1'b0);
        check("ovf_run_ignored", state_o, ST_IDLE);
        pulse_cmd(1'b1, 1'b0, 1'b0);
        check("reload_state", state_o, ST_LOAD);
        check("reload_err_clr", load_err, 0);

        // Reset pulsed while the 2nd of 4 words is offered
        send_word(32'hAAAA_0001, 1'b0);
        check("pre_rst_we", mem_we, 1);
        load_valid = 1'b1;
        load_data  = 32'hAAAA_0002;
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_we", mem_we, 0);
        check("midrst_state", state_o, ST_IDLE);
        check("midrst_ready", load_ready, 0);
        load_valid = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check("postrst_state", state_o, ST_IDLE);
        check("postrst_err", load_err, 0);

        // Fresh load, then 10 RUN cycles: 3 stalled, 2 redirects, halt on the last
        pulse_cmd(1'b1, 1'b0, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0000_0033, 1'b1);
        wait_state(ST_RUN, "perf_to_run");
        for (int i = 0; i < 10; i++) begin
            exp_stall    = (i == 1 || i == 2 || i == 5);
            hazard_stall = exp_stall;
            pcsrc_e      = (i == 4 || i == 9);
            halt_req     = (i == 9);
            #1;
            check($sformatf("run_stall_f_%0d", i), stall_f, exp_stall);
            step();
        end
        hazard_stall = 1'b0;
        pcsrc_e      = 1'b0;
        halt_req     = 1'b0;
        #1;
        check("perf_halt_state", state_o, ST_HALT);
        check("perf_halt_stall_f", stall_f, 1);
        repeat (5) step();
        check("halt_hold_stall_f", stall_f, 1);
`ifdef IMEM_SCHED_PERF_EN
        exp_fetch = 32'd7;
        exp_redir = 32'd2;
`else
        exp_fetch = 32'd0;
        exp_redir = 32'd0;
`endif
        check("fetch_cnt", fetch_cnt, exp_fetch);
        check("redir_cnt", redir_cnt, exp_redir);
        pulse_cmd(1'b0, 1'b1, 1'b0);
        check("resume_state", state_o, ST_RUN);
        check("resume_stall_f", stall_f, 0);
        check("resume_pc_rst", pc_rst, 0);
        repeat (2) step();
        check("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
